dram_rd_scheduler: RTL and testbench

- Decides which output queue next gets one DRAM block read (DRAM_BLOCK_SIZE bytes) into its on-chip read FIFO.
- Tracks, per queue, the number of blocks resident in DRAM and the free block slots (credits) in the queue's read FIFO.
- Issues one block read at a time to the DRAM read-side arbiter as a request/ack/done transaction, choosing eligible queues in round-robin order.

---
 rtl/dram_oq_pkg.sv | 23 ++
 rtl/rr_pick_eligible.sv | 32 +++
 rtl/dram_rd_scheduler.sv | 176 +++++++++++++++++
 tb/tb_dram_rd_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_oq_pkg.sv
// Shared definitions for the DRAM output-queue read/write schedulers.
package dram_oq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQ       = 2'd1,
      ST_WAIT_DONE = 2'd2
   } sched_state_e;

   localparam int DRAM_BLOCK_SIZE = 64;
   localparam int DEFAULT_NUM_OQ  = 8;

   // Ceiling log2, never less than 1 so single-queue builds still get an index bit.
   function automatic int log2(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_pick_eligible.sv
// Round-robin picker: first set bit of eligible searching upward from rr_ptr, wrapping at N-1.
module rr_pick_eligible #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] eligible,
   input  logic [W-1:0] rr_ptr,
   output logic         any_eligible,
   output logic [W-1:0] winner
);

   int         idx;
   logic [N-1:0] shifted;

   // Walk from the farthest offset back to rr_ptr so the nearest eligible queue wins.
   always_comb begin
      any_eligible = 1'b0;
      winner       = '0;
      idx          = 0;
      shifted      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         shifted = eligible >> idx;
         if (shifted[0]) begin
            any_eligible = 1'b1;
            winner       = W'(idx);
         end
      end
   end

endmodule

// File: rtl/dram_rd_scheduler.sv
// Round-robin DRAM block-read scheduler with per-queue block and credit tracking.
// Optional multi-block visits are enabled by defining DRAM_SCHED_BURST_EN.
//
// state        | meaning
// ST_IDLE      | waiting for enable and an eligible queue
// ST_REQ       | sched_req high for sched_oq, waiting for sched_ack
// ST_WAIT_DONE | block accepted, waiting for sched_done
module dram_rd_scheduler import dram_oq_pkg::*; #(
   parameter int NUM_OUTPUT_QUEUES = DEFAULT_NUM_OQ,
   parameter int NUM_OQ_WIDTH      = log2(NUM_OUTPUT_QUEUES),
   parameter int BLK_CNT_WIDTH     = 16,
   parameter int CREDIT_WIDTH      = 3,
   parameter int INIT_CREDITS      = 4,
   parameter int BURST_MAX         = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [NUM_OUTPUT_QUEUES-1:0] blk_written,
   input  logic [NUM_OUTPUT_QUEUES-1:0] credit_ret,
   output logic                         sched_req,
   output logic [NUM_OQ_WIDTH-1:0]      sched_oq,
   input  logic                         sched_ack,
   input  logic                         sched_done,
   output logic [NUM_OUTPUT_QUEUES-1:0] oq_nonempty,
   output logic                         err_overflow
);

   localparam int N = NUM_OUTPUT_QUEUES;
   localparam int W = NUM_OQ_WIDTH;

   if (N < 1 || N > 8 || INIT_CREDITS < 1 || INIT_CREDITS > (2**CREDIT_WIDTH) - 1 ||
       BURST_MAX < 1 || (DRAM_BLOCK_SIZE & (DRAM_BLOCK_SIZE - 1)) != 0) begin : g_param_check
      $error("dram_rd_scheduler: unsupported parameter set");
   end

   sched_state_e             state, state_nxt;
   logic [W-1:0]             oq_nxt, rr_ptr, rr_nxt, oq_inc, winner;
   logic                     any_eligible, ack_fire, done_fire, err_nxt;
   logic [N-1:0]             eligible, dec;
   logic [BLK_CNT_WIDTH-1:0] blk_cnt  [N];
   logic [BLK_CNT_WIDTH-1:0] blk_nxt  [N];
   logic [CREDIT_WIDTH-1:0]  credit   [N];
   logic [CREDIT_WIDTH-1:0]  cred_nxt [N];

`ifdef DRAM_SCHED_BURST_EN
   localparam int BURST_W = log2(BURST_MAX) + 1;
   logic [BURST_W-1:0] burst_cnt, burst_nxt;
   logic               stay_eligible;
`endif

   assign sched_req = (state == ST_REQ);
   assign ack_fire  = (state == ST_REQ) && sched_ack;
   assign oq_inc    = (sched_oq == W'(N - 1)) ? '0 : sched_oq + 1'b1;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         eligible[i] = (blk_cnt[i] != '0) && (credit[i] != '0);
         dec[i]      = ack_fire && (sched_oq == W'(i));
      end
   end

   rr_pick_eligible #(.N(N), .W(W)) u_pick (
      .eligible     (eligible),
      .rr_ptr       (rr_ptr),
      .any_eligible (any_eligible),
      .winner       (winner)
   );

   // Simultaneous increment and decrement cancel; saturation holds the value and flags it.
   always_comb begin
      err_nxt = err_overflow;
      for (int i = 0; i < N; i++) begin
         blk_nxt[i]  = blk_cnt[i];
         cred_nxt[i] = credit[i];
         if (blk_written[i] && !dec[i]) begin
            if (&blk_cnt[i]) err_nxt = 1'b1;
            else blk_nxt[i] = blk_cnt[i] + 1'b1;
         end else if (!blk_written[i] && dec[i]) begin
            blk_nxt[i] = blk_cnt[i] - 1'b1;
         end
         if (credit_ret[i] && !dec[i]) begin
            if (credit[i] == CREDIT_WIDTH'(INIT_CREDITS)) err_nxt = 1'b1;
            else cred_nxt[i] = credit[i] + 1'b1;
         end else if (!credit_ret[i] && dec[i]) begin
            cred_nxt[i] = credit[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            blk_cnt[i] <= '0;
            credit[i]  <= CREDIT_WIDTH'(INIT_CREDITS);
         end
         oq_nonempty  <= '0;
         err_overflow <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            blk_cnt[i]     <= blk_nxt[i];
            credit[i]      <= cred_nxt[i];
            oq_nonempty[i] <= (blk_nxt[i] != '0);
         end
         err_overflow <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      oq_nxt    = sched_oq;
      rr_nxt    = rr_ptr;
      done_fire = 1'b0;
`ifdef DRAM_SCHED_BURST_EN
      burst_nxt     = burst_cnt;
      stay_eligible = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sched_oq == W'(i)) stay_eligible = (blk_nxt[i] != '0) && (cred_nxt[i] != '0);
      end
`endif
      case (state)
         ST_IDLE: begin
            if (enable && any_eligible) begin
               state_nxt = ST_REQ;
               oq_nxt    = winner;
`ifdef DRAM_SCHED_BURST_EN
               burst_nxt = '0;
`endif
            end
         end
         ST_REQ: begin
            if (sched_ack) begin
`ifdef DRAM_SCHED_BURST_EN
               burst_nxt = burst_cnt + 1'b1;
`endif
               if (sched_done) done_fire = 1'b1;
               else state_nxt = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (sched_done) done_fire = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (done_fire) begin
         state_nxt = ST_IDLE;
         rr_nxt    = oq_inc;
`ifdef DRAM_SCHED_BURST_EN
         // Post-update counters decide whether the same queue can take another block.
         if (burst_nxt < BURST_W'(BURST_MAX) && stay_eligible) begin
            state_nxt = ST_REQ;
            rr_nxt    = rr_ptr;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         sched_oq <= '0;
         rr_ptr   <= '0;
`ifdef DRAM_SCHED_BURST_EN
         burst_cnt <= '0;
`endif
      end else begin
         state    <= state_nxt;
         sched_oq <= oq_nxt;
         rr_ptr   <= rr_nxt;
`ifdef DRAM_SCHED_BURST_EN
         burst_cnt <= burst_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_dram_rd_scheduler.sv
// Self-checking bench for dram_rd_scheduler: queue/array model plus directed scenarios.
module tb_dram_rd_scheduler;
   import dram_oq_pkg::*;

   localparam int N       = 8;
   localparam int INIT    = 4;
   localparam int BLK_MAX = 65535;
   localparam int BURST   = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic [7:0] blk_written = '0;
   logic [7:0] credit_ret = '0;
   logic       sched_req;
   logic [2:0] sched_oq;
   logic       sched_ack = 1'b0;
   logic       sched_done = 1'b0;
   logic [7:0] oq_nonempty;
   logic       err_overflow;

   int total = 0;
   int bad = 0;

   dram_rd_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .blk_written  (blk_written),
      .credit_ret   (credit_ret),
      .sched_req    (sched_req),
      .sched_oq     (sched_oq),
      .sched_ack    (sched_ack),
      .sched_done   (sched_done),
      .oq_nonempty  (oq_nonempty),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: per-queue counts, a transaction phase (0 free, 1 requesting, 2 awaiting done).
   int  m_blk [N];
   int  m_cred [N];
   int  m_phase, m_oq, m_rr, m_served;
   bit  m_err;
   bit  m_elig [N];
   int  m_pick, m_net, m_j;
   bit  m_ack, m_fin, m_cont;

   initial forever begin
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_blk[i] = 0;
            m_cred[i] = INIT;
         end
         m_phase = 0; m_oq = 0; m_rr = 0; m_served = 0; m_err = 0;
      end else begin
         for (int i = 0; i < N; i++) m_elig[i] = (m_blk[i] > 0) && (m_cred[i] > 0);
         m_ack = (m_phase == 1) && sched_ack;
         for (int i = 0; i < N; i++) begin
            m_net = int'(blk_written[i]) - ((m_ack && m_oq == i) ? 1 : 0);
            if (m_net > 0) begin
               if (m_blk[i] == BLK_MAX) m_err = 1; else m_blk[i]++;
            end else if (m_net < 0) m_blk[i]--;
            m_net = int'(credit_ret[i]) - ((m_ack && m_oq == i) ? 1 : 0);
            if (m_net > 0) begin
               if (m_cred[i] == INIT) m_err = 1; else m_cred[i]++;
            end else if (m_net < 0) m_cred[i]--;
         end
         m_fin = 0;
         if (m_phase == 0) begin
            if (enable) begin
               m_pick = -1;
               for (int k = 0; k < N; k++) begin
                  m_j = (m_rr + k) % N;
                  if (m_pick < 0 && m_elig[m_j]) m_pick = m_j;
               end
               if (m_pick >= 0) begin
                  m_oq = m_pick; m_phase = 1; m_served = 0;
               end
            end
         end else if (m_phase == 1) begin
            if (m_ack) begin
               m_served++;
               if (sched_done) m_fin = 1; else m_phase = 2;
            end
         end else if (sched_done) begin
            m_fin = 1;
         end
         if (m_fin) begin
            m_cont = 0;
`ifdef DRAM_SCHED_BURST_EN
            m_cont = (m_served < BURST) && (m_blk[m_oq] > 0) && (m_cred[m_oq] > 0);
`endif
            if (m_cont) m_phase = 1;
            else begin
               m_phase = 0;
               m_rr = (m_oq + 1) % N;
            end
         end
      end
   end

   logic [7:0] m_ne;
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) m_ne[i] = (m_blk[i] != 0);
      chk("cyc_req", sched_req, (m_phase == 1));
      chk("cyc_oq", sched_oq, m_oq);
      chk("cyc_nonempty", oq_nonempty, m_ne);
      chk("cyc_err", err_overflow, m_err);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_dut(input int cycles);
      reset = 1'b1;
      enable = 1'b1;
      blk_written = '0;
      credit_ret = '0;
      sched_ack = 1'b0;
      sched_done = 1'b0;
      repeat (cycles) step();
      reset = 1'b0;
   endtask

   task automatic pulse_blk(input logic [7:0] v);
      blk_written = v;
      step();
      blk_written = '0;
   endtask

   task automatic wait_req(output bit got);
      int n;
      n = 0;
      while (!sched_req && n < 40) begin
         step();
         n++;
      end
      got = sched_req;
   endtask

   task automatic do_txn(input int ack_wait, input int done_wait, input bit ret_credit,
                         output int oq, output bit got);
      oq = -1;
      wait_req(got);
      if (!got) return;
      oq = int'(sched_oq);
      repeat (ack_wait) step();
      if (done_wait == 0) begin
         sched_ack = 1'b1; sched_done = 1'b1;
         step();
         sched_ack = 1'b0; sched_done = 1'b0;
      end else begin
         sched_ack = 1'b1;
         step();
         sched_ack = 1'b0;
         repeat (done_wait - 1) step();
         sched_done = 1'b1;
         step();
         sched_done = 1'b0;
      end
      if (ret_credit) begin
         credit_ret[oq] = 1'b1;
         step();
         credit_ret = '0;
      end
   endtask

   int  oq_got;
   bit  got;
   int  cnt;
   int  exp_fair [6];
   int  exp_burst [7];

   initial begin
      exp_fair = '{0, 2, 7, 0, 2, 7};
`ifdef DRAM_SCHED_BURST_EN
      exp_burst = '{0, 0, 0, 0, 1, 0, 0};
`else
      exp_burst = '{0, 1, 0, 0, 0, 0, 0};
`endif

      // Reset values and single-queue transaction on q3
      reset_dut(3);
      chk("rst_req", sched_req, 0);
      chk("rst_oq", sched_oq, 0);
      chk("rst_nonempty", oq_nonempty, 0);
      chk("rst_err", err_overflow, 0);
      pulse_blk(8'h08);
      chk("q3_nonempty", oq_nonempty[3], 1);
      chk("q3_req_not_yet", sched_req, 0);
      step();
      chk("q3_req", sched_req, 1);
      chk("q3_oq", sched_oq, 3);
      sched_ack = 1'b1;
      step();
      sched_ack = 1'b0;
      chk("q3_req_drop", sched_req, 0);
      chk("q3_model_blk", m_blk[3], 0);
      chk("q3_model_cred", m_cred[3], 3);
      chk("q3_dut_cred", dut.credit[3], 3);
      step();
      sched_done = 1'b1;
      step();
      sched_done = 1'b0;
      repeat (5) step();
      chk("q3_no_more_req", sched_req, 0);

      // Round-robin fairness over q0, q2, q7 with wrap
      reset_dut(2);
      pulse_blk(8'h85);
      pulse_blk(8'h85);
      for (int t = 0; t < 6; t++) begin
         do_txn(2, 2, 1'b0, oq_got, got);
         chk("fair_got", got, 1);
         chk("fair_order", oq_got, exp_fair[t]);
      end

      // Credit stall on q1
      reset_dut(2);
      repeat (6) pulse_blk(8'h02);
      cnt = 0;
      for (int t = 0; t < 6; t++) begin
         do_txn(1, 1, 1'b0, oq_got, got);
         if (got) cnt++;
      end
      chk("stall_transfers", cnt, 4);
      chk("stall_nonempty", oq_nonempty[1], 1);
      chk("stall_model_blk", m_blk[1], 2);
      credit_ret = 8'h02;
      step();
      credit_ret = '0;
      cnt = 0;
      for (int t = 0; t < 2; t++) begin
         do_txn(1, 1, 1'b0, oq_got, got);
         if (got) cnt++;
      end
      chk("stall_one_more", cnt, 1);

      // Simultaneous write+ack on q5, then credit overflow
      reset_dut(2);
      pulse_blk(8'h20);
      wait_req(got);
      chk("sim_got", got, 1);
      sched_ack = 1'b1;
      blk_written = 8'h20;
      step();
      sched_ack = 1'b0;
      blk_written = '0;
      chk("sim_blk_model", m_blk[5], 1);
      chk("sim_blk_dut", dut.blk_cnt[5], 1);
      chk("sim_nonempty", oq_nonempty[5], 1);
      sched_done = 1'b1;
      step();
      sched_done = 1'b0;
      do_txn(0, 1, 1'b0, oq_got, got);
      chk("sim_second_oq", oq_got, 5);
      repeat (2) begin
         credit_ret = 8'h20;
         step();
         credit_ret = '0;
      end
      chk("ovf_before", err_overflow, 0);
      credit_ret = 8'h20;
      step();
      credit_ret = '0;
      chk("ovf_set", err_overflow, 1);
      repeat (3) step();
      chk("ovf_sticky", err_overflow, 1);

      // Enable low in ST_REQ, ack and done together
      reset_dut(2);
      pulse_blk(8'h04);
      pulse_blk(8'h04);
      wait_req(got);
      chk("en_got", got, 1);
      enable = 1'b0;
      blk_written = 8'h10;
      step();
      blk_written = '0;
      repeat (2) step();
      chk("en_req_held", sched_req, 1);
      sched_ack = 1'b1; sched_done = 1'b1;
      step();
      sched_ack = 1'b0; sched_done = 1'b0;
      chk("en_idle_state", dut.state, ST_IDLE);
      chk("en_req_drop", sched_req, 0);
      repeat (5) step();
      chk("en_no_grant", sched_req, 0);
      enable = 1'b1;
      do_txn(1, 1, 1'b0, oq_got, got);
      chk("en_next_oq", oq_got, 4);
      do_txn(1, 1, 1'b0, oq_got, got);
      chk("en_last_oq", oq_got, 2);

      // Reset while waiting for done
      reset_dut(2);
      pulse_blk(8'h02);
      pulse_blk(8'h02);
      wait_req(got);
      chk("rmid_got", got, 1);
      sched_ack = 1'b1;
      step();
      sched_ack = 1'b0;
      chk("rmid_in_wait", dut.state, ST_WAIT_DONE);
      reset_dut(1);
      chk("rmid_req", sched_req, 0);
      chk("rmid_nonempty", oq_nonempty, 0);
      for (int i = 0; i < N; i++) begin
         chk("rmid_cred", dut.credit[i], INIT);
         chk("rmid_blk", dut.blk_cnt[i], 0);
      end
      repeat (4) step();
      chk("rmid_quiet", sched_req, 0);

      // Visit order with 6 blocks in q0 and 1 in q1, credits returned after each block
      reset_dut(2);
      pulse_blk(8'h03);
      repeat (5) pulse_blk(8'h01);
      for (int t = 0; t < 7; t++) begin
         do_txn(1, 1, 1'b1, oq_got, got);
         chk("visit_got", got, 1);
         chk("visit_order", oq_got, exp_burst[t]);
      end
      repeat (4) step();
      chk("visit_drained", oq_nonempty, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
